board_state_ctrl: RTL and testbench
===================================

# board_state_ctrl

Parametrised board-state controller for the chess design. Holds the board as a register array, initialises the standard opening layout on reset, and moves a cursor from debounced button pulses. Performs select-then-place piece moves with turn alternation and own-piece protection. It sits between the input debouncers and the display/rules logic, and exposes a registered read port for the renderer.

## Interface
Parameters:
- ROW_BITS, 3, log2 of board rows; ROWS = 2^ROW_BITS, minimum 4
- COL_BITS, 3, log2 of board columns; COLS = 2^COL_BITS, minimum 3

Ports:
- ClkPort  in  1  system clock; one clock, all state on the rising edge
- Reset  in  1  asynchronous, active-low reset
- BtnU_pulse, BtnD_pulse, BtnL_pulse, BtnR_pulse  in  1 each  one-cycle debounced direction pulses
- BtnC_pulse  in  1  one-cycle select/place pulse
- rd_addr  in  ROW_BITS+COL_BITS  display read address {row,col}
- rd_data  out  4  {color, piece} at rd_addr, registered
- cursor_row  out  ROW_BITS  current cursor row
- cursor_col  out  COL_BITS  current cursor column
- sel_valid  out  1  a source square is held
- sel_row  out  ROW_BITS  held source square row
- sel_col  out  COL_BITS  held source square column
- turn  out  1  side to move; 0 = white, 1 = black
- move_done  out  1  one-cycle pulse when a move commits

## Operation
- Square encoding: {color, piece[2:0]}. Piece codes: NONE 000, PAWN 001, KNIGHT 010, BISHOP 011, ROOK 100, QUEEN 101, KING 110. White = 0, black = 1. Empty square = 4'b0000.
- Reset layout:
  - Row 0: black back rank. Row 1: black pawns.
  - Row ROWS-2: white pawns. Row ROWS-1: white back rank.
  - Back-rank column c takes piece pattern[c mod 8] from R,N,B,Q,K,B,N,R.
  - All other squares are 0000.
- Own piece: piece != NONE and color == turn.
- FSM states: IDLE, HELD, WR_DST, WR_SRC.
  - IDLE, C on own piece: capture cursor into sel_row/sel_col, go to HELD. C on any other square: ignored.
  - HELD, C on the held square: deselect, go to IDLE.
  - HELD, C on another own piece: reselect that square, stay in HELD.
  - HELD, C on empty or opponent square: latch destination = cursor, go to WR_DST.
  - WR_DST: write held piece to destination, go to WR_SRC.
  - WR_SRC: write 0000 to source, toggle turn, pulse move_done, clear sel_valid, go to IDLE.
- Cursor (from reset value row ROWS-2, col COLS/2):
  - U decrements row, D increments row, L decrements column, R increments column.
  - Edge behaviour is set by the configuration macro.
  - If several direction pulses arrive in one cycle, only the highest priority applies: U > D > L > R.
  - If C and a direction pulse arrive together, C is evaluated at the pre-move cursor and the cursor also moves.
- All button inputs are ignored in WR_DST and WR_SRC.
- sel_valid is 1 in HELD, WR_DST and WR_SRC.
- No move-legality rules beyond the own-piece checks. A pawn on a far rank is not promoted.

## Timing
- rd_data: one-cycle latency from rd_addr. It reflects board contents as of the prior edge, so a same-cycle write is not forwarded.
- Move commit: C accepted at edge N. Destination updates at N+1. Source clears, turn toggles and move_done is high at N+2. Next C is accepted from N+3.
- Cursor and selection update on the edge that samples the pulse.
- Reset outputs: rd_data 0000, cursor (ROWS-2, COLS/2), sel_valid 0, sel_row 0, sel_col 0, turn 0, move_done 0. FSM returns to IDLE.
- Reset asserted mid-move, including in WR_DST: the board reverts to the opening layout immediately and the partial move is discarded.

## Configuration
- CURSOR_WRAP_EN defined: the cursor wraps at the edges. Row 0 + U gives ROWS-1; column COLS-1 + R gives 0.
- CURSOR_WRAP_EN undefined: the cursor saturates at the edges, and an out-of-range press leaves it unchanged.

## Test plan
- Reset, then read all 64 squares (8x8): square 0 = 1100, square 4 = 1110, square 8 = 1001, square 52 = 0001, square 60 = 0110, square 32 = 0000.
- Cursor (6,4), C, U, U, C: square (4,4) reads 0001, (6,4) reads 0000, move_done high 2 cycles after the second C, turn = 1.
- Turn 0, cursor on a black pawn, C: sel_valid stays 0. Then C on (6,4), move to (7,4) (white king), C: sel_valid stays 1, move_done never pulses, board unchanged.
- Cursor (0,0), U pulse: with CURSOR_WRAP_EN, cursor_row = 7; without it, cursor_row = 0.
- U and L pulses in the same cycle from (6,4): cursor = (5,4). Reset asserted in WR_DST: square (6,4) reads 0001 and turn = 0 after reset.
- ROW_BITS=4, COL_BITS=4: square (0,9) = 1010, (14,15) = 0001, (15,12) = 0110.

Source files
------------

// File: rtl/board_state_ctrl_if.sv
// Button, display-read and status bundle for the chess board-state controller.
// Pure wiring: no storage and no added latency.
// Backpressure: none; the pulses are one-cycle strobes and the read port is free-running.
interface board_state_ctrl_if #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3
);
  logic                         BtnU_pulse;
  logic                         BtnD_pulse;
  logic                         BtnL_pulse;
  logic                         BtnR_pulse;
  logic                         BtnC_pulse;
  logic [ROW_BITS+COL_BITS-1:0] rd_addr;
  logic [3:0]                   rd_data;
  logic [ROW_BITS-1:0]          cursor_row;
  logic [COL_BITS-1:0]          cursor_col;
  logic                         sel_valid;
  logic [ROW_BITS-1:0]          sel_row;
  logic [COL_BITS-1:0]          sel_col;
  logic                         turn;
  logic                         move_done;

  // Producer side: debouncers plus the renderer's read address.
  modport master (
    output BtnU_pulse, BtnD_pulse, BtnL_pulse, BtnR_pulse, BtnC_pulse, rd_addr,
    input  rd_data, cursor_row, cursor_col, sel_valid, sel_row, sel_col, turn, move_done
  );

  // Controller side.
  modport slave (
    input  BtnU_pulse, BtnD_pulse, BtnL_pulse, BtnR_pulse, BtnC_pulse, rd_addr,
    output rd_data, cursor_row, cursor_col, sel_valid, sel_row, sel_col, turn, move_done
  );
endinterface

// File: rtl/board_state_ctrl.sv
// Chess board register array with cursor, select-then-place moves and turn alternation.
// Latency: rd_data 1 cycle; a move lands on the destination 1 edge and clears the source 2 edges after C.
// Backpressure: none; buttons are simply ignored while a move is being written. CURSOR_WRAP_EN selects wrap vs saturate.
module board_state_ctrl #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3
) (
  input logic            ClkPort,
  input logic            Reset,
  board_state_ctrl_if.slave bus
);
  localparam int ADDR_W  = ROW_BITS + COL_BITS;
  localparam int ROWS    = 1 << ROW_BITS;
  localparam int COLS    = 1 << COL_BITS;
  localparam int SQUARES = 1 << ADDR_W;

  localparam logic [ROW_BITS-1:0] ROW_MAX   = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_MAX   = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_START = ROW_BITS'(ROWS - 2);
  localparam logic [COL_BITS-1:0] COL_START = COL_BITS'(COLS / 2);

  typedef enum logic [1:0] {IDLE, HELD, WR_DST, WR_SRC} state_t;

  state_t              state, stateNext;
  logic [3:0]          board [SQUARES];
  logic [3:0]          rdData;
  logic [ROW_BITS-1:0] cursorRow, rowNext, selRow, dstRow;
  logic [COL_BITS-1:0] cursorCol, colNext, selCol, dstCol;
  logic                turnQ, moveDone;
  logic                btnEn, cFire, ownSq, onHeld, capSel, latchDst;
  logic [3:0]          curSq;

  // Opening layout: back ranks repeat R,N,B,Q,K,B,N,R every 8 columns; black on top.
  function automatic logic [3:0] initSquare(input logic [ROW_BITS-1:0] r, input logic [2:0] c3);
    logic [2:0] backPiece;
    logic [3:0] sq;
    case (c3)
      3'd0, 3'd7: backPiece = 3'b100;
      3'd1, 3'd6: backPiece = 3'b010;
      3'd2, 3'd5: backPiece = 3'b011;
      3'd3:       backPiece = 3'b101;
      default:    backPiece = 3'b110;
    endcase
    if (r == '0)                        sq = {1'b1, backPiece};
    else if (r == ROW_BITS'(1))         sq = 4'b1001;
    else if (r == ROW_START)            sq = 4'b0001;
    else if (r == ROW_MAX)              sq = {1'b0, backPiece};
    else                                sq = 4'b0000;
    return sq;
  endfunction

  assign btnEn  = (state == IDLE) || (state == HELD);
  assign cFire  = btnEn && bus.BtnC_pulse;
  assign curSq  = board[{cursorRow, cursorCol}];
  assign ownSq  = (curSq[2:0] != 3'b000) && (curSq[3] == turnQ);
  assign onHeld = (cursorRow == selRow) && (cursorCol == selCol);

  // FSM state register.
  always_ff @(posedge ClkPort or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state plus selection/destination capture strobes; C uses the pre-move cursor.
  always_comb begin
    stateNext = state;
    capSel    = 1'b0;
    latchDst  = 1'b0;
    case (state)
      IDLE: if (cFire && ownSq) begin
        capSel    = 1'b1;
        stateNext = HELD;
      end
      HELD: if (cFire) begin
        if (onHeld) begin
          stateNext = IDLE;
        end else if (ownSq) begin
          capSel = 1'b1;
        end else begin
          latchDst  = 1'b1;
          stateNext = WR_DST;
        end
      end
      WR_DST:  stateNext = WR_SRC;
      WR_SRC:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Cursor step: one direction per cycle with U > D > L > R priority.
  always_comb begin
    rowNext = cursorRow;
    colNext = cursorCol;
    if (btnEn) begin
`ifdef CURSOR_WRAP_EN
      if (bus.BtnU_pulse)      rowNext = cursorRow - ROW_BITS'(1);
      else if (bus.BtnD_pulse) rowNext = cursorRow + ROW_BITS'(1);
      else if (bus.BtnL_pulse) colNext = cursorCol - COL_BITS'(1);
      else if (bus.BtnR_pulse) colNext = cursorCol + COL_BITS'(1);
`else
      if (bus.BtnU_pulse) begin
        if (cursorRow != '0) rowNext = cursorRow - ROW_BITS'(1);
      end else if (bus.BtnD_pulse) begin
        if (cursorRow != ROW_MAX) rowNext = cursorRow + ROW_BITS'(1);
      end else if (bus.BtnL_pulse) begin
        if (cursorCol != '0) colNext = cursorCol - COL_BITS'(1);
      end else if (bus.BtnR_pulse) begin
        if (cursorCol != COL_MAX) colNext = cursorCol + COL_BITS'(1);
      end
`endif
    end
  end

  // Cursor, selection, destination, turn and move-done pulse registers.
  always_ff @(posedge ClkPort or negedge Reset) begin
    if (!Reset) begin
      cursorRow <= ROW_START;
      cursorCol <= COL_START;
      selRow    <= '0;
      selCol    <= '0;
      dstRow    <= '0;
      dstCol    <= '0;
      turnQ     <= 1'b0;
      moveDone  <= 1'b0;
    end else begin
      cursorRow <= rowNext;
      cursorCol <= colNext;
      if (capSel) begin
        selRow <= cursorRow;
        selCol <= cursorCol;
      end
      if (latchDst) begin
        dstRow <= cursorRow;
        dstCol <= cursorCol;
      end
      if (state == WR_SRC) turnQ <= ~turnQ;
      moveDone <= (state == WR_SRC);
    end
  end

  // Board storage: reset reloads the opening so a half-written move is discarded.
  always_ff @(posedge ClkPort or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < SQUARES; i++) begin
        board[i] <= initSquare(ROW_BITS'(i >> COL_BITS), 3'(i));
      end
    end else if (state == WR_DST) begin
      board[{dstRow, dstCol}] <= board[{selRow, selCol}];
    end else if (state == WR_SRC) begin
      board[{selRow, selCol}] <= 4'b0000;
    end
  end

  // Renderer read port; samples pre-edge contents, so same-edge writes show up a cycle later.
  always_ff @(posedge ClkPort or negedge Reset) begin
    if (!Reset) rdData <= 4'b0000;
    else        rdData <= board[bus.rd_addr];
  end

  assign bus.rd_data    = rdData;
  assign bus.cursor_row = cursorRow;
  assign bus.cursor_col = cursorCol;
  assign bus.sel_valid  = (state != IDLE);
  assign bus.sel_row    = selRow;
  assign bus.sel_col    = selCol;
  assign bus.turn       = turnQ;
  assign bus.move_done  = moveDone;
endmodule

// File: tb/tb_board_state_ctrl.sv
// Directed bench for board_state_ctrl: 8x8 and 16x16 instances on one clock/reset.
// Inputs driven and outputs sampled on the falling edge.
// Expected values are hand-derived constants plus an opening-layout table.
module tb_board_state_ctrl;
  logic ClkPort = 1'b0;
  logic Reset   = 1'b0;
  int   checkCount = 0;
  int   failCount  = 0;
  int   v;
  int   backRank [8] = '{4, 2, 3, 5, 6, 3, 2, 4};

  always #5 ClkPort = ~ClkPort;

  board_state_ctrl_if #(.ROW_BITS(3), .COL_BITS(3)) bus8 ();
  board_state_ctrl_if #(.ROW_BITS(4), .COL_BITS(4)) bus16 ();

  board_state_ctrl #(.ROW_BITS(3), .COL_BITS(3)) dut8 (
    .ClkPort(ClkPort), .Reset(Reset), .bus(bus8.slave)
  );
  board_state_ctrl #(.ROW_BITS(4), .COL_BITS(4)) dut16 (
    .ClkPort(ClkPort), .Reset(Reset), .bus(bus16.slave)
  );

  task automatic checkEq(input string tag, input int got, input int exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press(input bit u, input bit d, input bit l, input bit r, input bit c);
    @(negedge ClkPort);
    bus8.BtnU_pulse = u; bus8.BtnD_pulse = d; bus8.BtnL_pulse = l;
    bus8.BtnR_pulse = r; bus8.BtnC_pulse = c;
    @(negedge ClkPort);
    bus8.BtnU_pulse = 0; bus8.BtnD_pulse = 0; bus8.BtnL_pulse = 0;
    bus8.BtnR_pulse = 0; bus8.BtnC_pulse = 0;
  endtask

  task automatic pressN(input int n, input bit u, input bit d, input bit l, input bit r);
    for (int k = 0; k < n; k++) press(u, d, l, r, 1'b0);
  endtask

  task automatic checkSq(input string tag, input int row, input int col, input int exp);
    @(negedge ClkPort);
    bus8.rd_addr = 6'(row * 8 + col);
    @(negedge ClkPort);
    checkEq(tag, int'(bus8.rd_data), exp);
  endtask

  task automatic checkSq16(input string tag, input int row, input int col, input int exp);
    @(negedge ClkPort);
    bus16.rd_addr = 8'(row * 16 + col);
    @(negedge ClkPort);
    checkEq(tag, int'(bus16.rd_data), exp);
  endtask

  task automatic doReset();
    @(negedge ClkPort);
    Reset = 1'b0;
    @(negedge ClkPort);
    Reset = 1'b1;
  endtask

  function automatic int expOpening(input int row, input int col);
    if (row == 0) return 8 + backRank[col % 8];
    if (row == 1) return 9;
    if (row == 6) return 1;
    if (row == 7) return backRank[col % 8];
    return 0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus8.BtnU_pulse = 0; bus8.BtnD_pulse = 0; bus8.BtnL_pulse = 0;
    bus8.BtnR_pulse = 0; bus8.BtnC_pulse = 0; bus8.rd_addr = '0;
    bus16.BtnU_pulse = 0; bus16.BtnD_pulse = 0; bus16.BtnL_pulse = 0;
    bus16.BtnR_pulse = 0; bus16.BtnC_pulse = 0; bus16.rd_addr = '0;

    // Reset state
    @(negedge ClkPort);
    @(negedge ClkPort);
    checkEq("rst_rd_data", int'(bus8.rd_data), 0);
    Reset = 1'b1;
    @(negedge ClkPort);
    checkEq("rst_cursor_row", int'(bus8.cursor_row), 6);
    checkEq("rst_cursor_col", int'(bus8.cursor_col), 4);
    checkEq("rst_sel_valid", int'(bus8.sel_valid), 0);
    checkEq("rst_sel_row", int'(bus8.sel_row), 0);
    checkEq("rst_sel_col", int'(bus8.sel_col), 0);
    checkEq("rst_turn", int'(bus8.turn), 0);
    checkEq("rst_move_done", int'(bus8.move_done), 0);
    checkEq("rst16_cursor_row", int'(bus16.cursor_row), 14);
    checkEq("rst16_cursor_col", int'(bus16.cursor_col), 8);

    // Opening layout
    checkSq("sq0", 0, 0, 4'b1100);
    checkSq("sq4", 0, 4, 4'b1110);
    checkSq("sq8", 1, 0, 4'b1001);
    checkSq("sq52", 6, 4, 4'b0001);
    checkSq("sq60", 7, 4, 4'b0110);
    checkSq("sq32", 4, 0, 4'b0000);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        checkSq($sformatf("open_%0d_%0d", r, c), r, c, expOpening(r, c));

    // White pawn (6,4) -> (4,4), with commit timing
    press(0, 0, 0, 0, 1);
    checkEq("sel_valid_after_c", int'(bus8.sel_valid), 1);
    checkEq("sel_row_after_c", int'(bus8.sel_row), 6);
    checkEq("sel_col_after_c", int'(bus8.sel_col), 4);
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    checkEq("cursor_row_uu", int'(bus8.cursor_row), 4);
    @(negedge ClkPort);
    bus8.rd_addr = 6'(4 * 8 + 4);
    bus8.BtnC_pulse = 1;
    @(negedge ClkPort);                       // edge N
    bus8.BtnC_pulse = 0;
    checkEq("n_sel_valid", int'(bus8.sel_valid), 1);
    checkEq("n_move_done", int'(bus8.move_done), 0);
    @(negedge ClkPort);                       // edge N+1
    checkEq("n1_move_done", int'(bus8.move_done), 0);
    checkEq("n1_turn", int'(bus8.turn), 0);
    checkEq("n1_no_forward", int'(bus8.rd_data), 0);
    @(negedge ClkPort);                       // edge N+2
    checkEq("n2_move_done", int'(bus8.move_done), 1);
    checkEq("n2_turn", int'(bus8.turn), 1);
    checkEq("n2_sel_valid", int'(bus8.sel_valid), 0);
    checkEq("n2_dst_read", int'(bus8.rd_data), 4'b0001);
    @(negedge ClkPort);
    checkEq("n3_move_done", int'(bus8.move_done), 0);
    checkSq("moved_dst", 4, 4, 4'b0001);
    checkSq("moved_src", 6, 4, 4'b0000);

    // Own-piece protection, reselect and deselect
    doReset();
    pressN(5, 1, 0, 0, 0);
    checkEq("at_black_pawn_row", int'(bus8.cursor_row), 1);
    press(0, 0, 0, 0, 1);
    checkEq("opp_sel_valid", int'(bus8.sel_valid), 0);
    pressN(5, 0, 1, 0, 0);
    press(0, 0, 0, 0, 1);
    checkEq("own_sel_valid", int'(bus8.sel_valid), 1);
    press(0, 1, 0, 0, 0);
    @(negedge ClkPort);
    bus8.BtnC_pulse = 1;
    @(negedge ClkPort);
    bus8.BtnC_pulse = 0;
    for (int k = 0; k < 4; k++) begin
      checkEq($sformatf("reselect_no_done_%0d", k), int'(bus8.move_done), 0);
      @(negedge ClkPort);
    end
    checkEq("reselect_sel_valid", int'(bus8.sel_valid), 1);
    checkEq("reselect_sel_row", int'(bus8.sel_row), 7);
    checkEq("reselect_turn", int'(bus8.turn), 0);
    checkSq("reselect_king", 7, 4, 4'b0110);
    checkSq("reselect_pawn", 6, 4, 4'b0001);
    press(0, 0, 0, 0, 1);
    checkEq("deselect_sel_valid", int'(bus8.sel_valid), 0);

    // Edges at (0,0)
    pressN(7, 1, 0, 0, 0);
    pressN(4, 0, 0, 1, 0);
    checkEq("corner_row", int'(bus8.cursor_row), 0);
    checkEq("corner_col", int'(bus8.cursor_col), 0);
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
`ifdef CURSOR_WRAP_EN
    checkEq("edge_u_row", int'(bus8.cursor_row), 7);
    checkEq("edge_l_col", int'(bus8.cursor_col), 7);
`else
    checkEq("edge_u_row", int'(bus8.cursor_row), 0);
    checkEq("edge_l_col", int'(bus8.cursor_col), 0);
`endif

    // Direction priority
    doReset();
    press(1, 0, 1, 0, 0);
    checkEq("prio_ul_row", int'(bus8.cursor_row), 5);
    checkEq("prio_ul_col", int'(bus8.cursor_col), 4);
    press(0, 1, 0, 1, 0);
    checkEq("prio_dr_row", int'(bus8.cursor_row), 6);
    checkEq("prio_dr_col", int'(bus8.cursor_col), 4);
    press(0, 0, 1, 1, 0);
    checkEq("prio_lr_col", int'(bus8.cursor_col), 3);
    press(0, 0, 0, 1, 0);

    // C with a direction, then reset during WR_DST
    press(1, 0, 0, 0, 1);
    checkEq("cu_sel_valid", int'(bus8.sel_valid), 1);
    checkEq("cu_sel_row", int'(bus8.sel_row), 6);
    checkEq("cu_cursor_row", int'(bus8.cursor_row), 5);
    @(negedge ClkPort);
    bus8.BtnC_pulse = 1;
    @(negedge ClkPort);
    bus8.BtnC_pulse = 0;
    checkEq("wrdst_sel_valid", int'(bus8.sel_valid), 1);
    Reset = 1'b0;
    @(negedge ClkPort);
    Reset = 1'b1;
    checkEq("abort_turn", int'(bus8.turn), 0);
    checkEq("abort_sel_valid", int'(bus8.sel_valid), 0);
    checkSq("abort_src", 6, 4, 4'b0001);
    checkSq("abort_dst", 5, 4, 4'b0000);
    checkEq("abort_move_done", int'(bus8.move_done), 0);

    // 16x16 layout
    checkSq16("big_0_9", 0, 9, 4'b1010);
    checkSq16("big_14_15", 14, 15, 4'b0001);
    checkSq16("big_15_12", 15, 12, 4'b0110);
    checkSq16("big_1_3", 1, 3, 4'b1001);
    checkSq16("big_8_8", 8, 8, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end
endmodule
